// File: rtl/dcmac_0_axis_pkt_gen_dat_split_if.sv
// -----------------------------------------------------------------------------
// dcmac_0_axis_pkt_gen_dat_split_if
//
// Purpose: segment-beat type and the bus bundle for the packet-generator data
// splitter. The package defines lbus_pkt_t, the 12-segment x 16-byte output
// beat. The interface groups the chunk input handshake, the chunk payload and
// the output beat handshake.
//
// Handshakes (strict valid/ready): a chunk transfers on a rising clk edge
// where i_valid && o_ready; an output beat transfers on a rising clk edge
// where o_valid && i_tx_rdy. A source holds its payload stable while its
// valid is high and the transfer has not happened.
//
// Signals:
//   i_valid, o_ready        chunk handshake
//   i_id[2:0]               channel id of the chunk
//   i_size[7:0]             valid bytes in the chunk (1..192)
//   i_eop, i_err            chunk ends a packet / packet error mark
//   i_dat[191:0][7:0]       chunk bytes, byte k at i_dat[k]
//   i_tx_rdy, o_valid       output beat handshake
//   o_pkt                   output beat (lbus_pkt_t)
//   o_size_err              one-cycle pulse when a malformed chunk is dropped
// Modports: master = chunk source / beat sink, slave = the splitter.
// -----------------------------------------------------------------------------
package dcmac_0_axis_pkt_gen_dat_split_pkg;
    typedef struct packed {
        logic [2:0]         id;
        logic [11:0]        ena;
        logic [11:0]        sop;
        logic [11:0]        eop;
        logic [11:0]        err;
        logic [11:0][3:0]   mty;
        logic [11:0][127:0] dat;
    } lbus_pkt_t;
endpackage

interface dcmac_0_axis_pkt_gen_dat_split_if;
    import dcmac_0_axis_pkt_gen_dat_split_pkg::*;

    logic              i_valid;
    logic              o_ready;
    logic [2:0]        i_id;
    logic [7:0]        i_size;
    logic              i_eop;
    logic              i_err;
    logic [191:0][7:0] i_dat;
    logic              i_tx_rdy;
    logic              o_valid;
    lbus_pkt_t         o_pkt;
    logic              o_size_err;

    modport master (
        output i_valid, i_id, i_size, i_eop, i_err, i_dat, i_tx_rdy,
        input  o_ready, o_valid, o_pkt, o_size_err
    );

    modport slave (
        input  i_valid, i_id, i_size, i_eop, i_err, i_dat, i_tx_rdy,
        output o_ready, o_valid, o_pkt, o_size_err
    );
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_dat_split.sv
// -----------------------------------------------------------------------------
// dcmac_0_axis_pkt_gen_dat_split
//
// Purpose: transmit-side packet-generator data splitter. Byte chunks (up to
// 192 bytes) are packed into an accumulator of 12 x 16-byte segments with
// per-segment ena/sop/eop/err/mty, then moved into an output register that
// drives the LBUS-style beat. Several chunks share one beat while they fit and
// carry the same channel id; an eop chunk pads the write pointer to the next
// 4-segment quad so each quad holds at most one eop.
//
// Ports:
//   clk    datapath clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dcmac_0_axis_pkt_gen_dat_split_if.slave (chunk in, beat out)
//
// Optional feature: define DCMAC_0_PKT_GEN_ERR_INJ_EN to propagate i_err to
// the err bit of the packet's eop segment. Without it err is always zero.
// -----------------------------------------------------------------------------
module dcmac_0_axis_pkt_gen_dat_split
    import dcmac_0_axis_pkt_gen_dat_split_pkg::*;
(
    input logic clk,
    input logic rst_n,
    dcmac_0_axis_pkt_gen_dat_split_if.slave bus
);

    lbus_pkt_t acc;        // accumulator; acc.id is the accumulator channel id
    lbus_pkt_t acc_nxt;
    lbus_pkt_t base;
    lbus_pkt_t pkt_q;
    logic [3:0] wp;
    logic [3:0] wp_nxt;
    logic [3:0] base_wp;
    logic       in_pkt;
    logic       in_pkt_nxt;
    logic       rdy_en;    // keeps o_ready low until the first clock after reset
    logic       valid_q;
    logic       size_err_q;

    logic       slot_free;
    logic       acc_full;
    logic       malformed;
    logic       ready;
    logic       fire;
    logic       good;
    logic       need_split;
    logic       xfer;
    logic [3:0] n;
    logic [4:0] seg_end;
    logic [4:0] pad_end;
    logic [3:0] seg;
    logic [7:0] byte_idx;
    logic       err_bit;

`ifdef DCMAC_0_PKT_GEN_ERR_INJ_EN
    logic err_lat;         // i_err seen on an earlier chunk of the open packet
`else
    logic unused_err;
    assign unused_err = bus.i_err;
`endif

    always_comb begin
        slot_free = !valid_q || bus.i_tx_rdy;
        acc_full  = (wp == 4'd12);
        n         = 4'((9'(bus.i_size) + 9'd15) >> 4);
        malformed = (bus.i_size == 8'd0) || (bus.i_size > 8'd192) ||
                    (!bus.i_eop && (bus.i_size[3:0] != 4'd0));
        ready     = rdy_en && slot_free && !acc_full;
        fire      = bus.i_valid && ready;
        good      = fire && !malformed;
        // A well-formed chunk that cannot join the current accumulator
        // forces the accumulator out; it is then written at segment 0.
        need_split = bus.i_valid && !malformed && (wp != 4'd0) &&
                     (((5'(wp) + 5'(n)) > 5'd12) || (bus.i_id != acc.id));
        xfer = slot_free &&
               (acc_full || ((wp != 4'd0) && !good) || need_split);

`ifdef DCMAC_0_PKT_GEN_ERR_INJ_EN
        err_bit = bus.i_err || err_lat;
`else
        err_bit = 1'b0;
`endif

        base       = xfer ? '0 : acc;
        base_wp    = xfer ? 4'd0 : wp;
        seg_end    = 5'(base_wp) + 5'(n);
        pad_end    = seg_end + 5'd3;
        seg        = 4'd0;
        byte_idx   = 8'd0;
        acc_nxt    = base;
        wp_nxt     = base_wp;
        in_pkt_nxt = in_pkt;

        if (good) begin
            for (int s = 0; s < 12; s++) begin
                if ((5'(s) >= 5'(base_wp)) && (5'(s) < seg_end)) begin
                    seg      = 4'(s) - base_wp;
                    byte_idx = {seg, 4'b0000};
                    acc_nxt.ena[s] = 1'b1;
                    acc_nxt.dat[s] = bus.i_dat[byte_idx +: 16];
                    if (4'(s) == base_wp) begin
                        acc_nxt.sop[s] = !in_pkt;
                    end
                    if (bus.i_eop && (5'(s) == seg_end - 5'd1)) begin
                        acc_nxt.eop[s] = 1'b1;
                        acc_nxt.mty[s] = 4'(5'd16 - 5'(bus.i_size[3:0]));
                        acc_nxt.err[s] = err_bit;
                    end
                end
            end
            acc_nxt.id = bus.i_id;
            if (bus.i_eop) begin
                wp_nxt     = 4'({pad_end[4:2], 2'b00});
                in_pkt_nxt = 1'b0;
            end else begin
                wp_nxt     = 4'(seg_end);
                in_pkt_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            wp         <= 4'd0;
            in_pkt     <= 1'b0;
            rdy_en     <= 1'b0;
            pkt_q      <= '0;
            valid_q    <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            wp         <= wp_nxt;
            in_pkt     <= in_pkt_nxt;
            rdy_en     <= 1'b1;
            size_err_q <= fire && malformed;
            if (xfer) begin
                pkt_q   <= acc;
                valid_q <= 1'b1;
            end else if (bus.i_tx_rdy) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef DCMAC_0_PKT_GEN_ERR_INJ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_lat <= 1'b0;
        end else if (good) begin
            err_lat <= bus.i_eop ? 1'b0 : (err_lat || bus.i_err);
        end
    end
`endif

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_pkt      = pkt_q;
    assign bus.o_size_err = size_err_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_dat_split.sv
// -----------------------------------------------------------------------------
// tb_dcmac_0_axis_pkt_gen_dat_split
//
// Directed bench for the packet-generator data splitter. Expected beats are
// built from hand-chosen segment positions and flags and queued when the
// chunks are issued; a negedge monitor pops and compares every beat the DUT
// hands over, and checks that a stalled beat holds steady.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcmac_0_axis_pkt_gen_dat_split;
    import dcmac_0_axis_pkt_gen_dat_split_pkg::*;

    localparam int PKT_W = $bits(lbus_pkt_t);
`ifdef DCMAC_0_PKT_GEN_ERR_INJ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    dcmac_0_axis_pkt_gen_dat_split_if bus();

    dcmac_0_axis_pkt_gen_dat_split dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total;
    int bad;
    int serr_cnt;
    logic [PKT_W-1:0] exp_q[$];
    lbus_pkt_t eb;
    lbus_pkt_t hold_pkt;
    bit hold_v;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int tag, input int k);
        return 8'((tag * 41 + k * 7 + 3) & 255);
    endfunction

    task automatic check_beat(input lbus_pkt_t a, input lbus_pkt_t e);
        int first_bad;
        chk("beat_id",  64'(a.id),  64'(e.id));
        chk("beat_ena", 64'(a.ena), 64'(e.ena));
        chk("beat_sop", 64'(a.sop), 64'(e.sop));
        chk("beat_eop", 64'(a.eop), 64'(e.eop));
        chk("beat_err", 64'(a.err), 64'(e.err));
        chk("beat_mty", 64'(a.mty), 64'(e.mty));
        total++;
        if (a.dat !== e.dat) begin
            bad++;
            first_bad = 0;
            for (int s = 11; s >= 0; s--) if (a.dat[s] !== e.dat[s]) first_bad = s;
            $display("FAIL beat_dat seg=%0d actual=%h required=%h",
                     first_bad, a.dat[first_bad], e.dat[first_bad]);
        end
    endtask

    // ---------------- expected beat construction ----------------
    task automatic exp_new(input logic [2:0] id);
        eb = '0;
        eb.id = id;
    endtask

    task automatic exp_chunk(input int seg0, input int nseg, input int tag,
                             input bit sop, input bit eop, input int mty, input bit err);
        for (int s = 0; s < nseg; s++) begin
            eb.ena[seg0 + s] = 1'b1;
            for (int b = 0; b < 16; b++) eb.dat[seg0 + s][b*8 +: 8] = pat(tag, s * 16 + b);
        end
        if (sop) eb.sop[seg0] = 1'b1;
        if (eop) begin
            eb.eop[seg0 + nseg - 1] = 1'b1;
            eb.mty[seg0 + nseg - 1] = 4'(mty);
            eb.err[seg0 + nseg - 1] = err;
        end
    endtask

    task automatic exp_push();
        exp_q.push_back(PKT_W'(eb));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v) begin
                total++;
                if (bus.o_pkt !== hold_pkt) begin
                    bad++;
                    $display("FAIL stall_hold id/ena actual=%h/%h required=%h/%h",
                             bus.o_pkt.id, bus.o_pkt.ena, hold_pkt.id, hold_pkt.ena);
                end
            end
            hold_v = 1'b0;
            if (bus.o_valid === 1'b1) begin
                if (bus.i_tx_rdy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual_ena=%h required=none", bus.o_pkt.ena);
                    end else begin
                        check_beat(bus.o_pkt, lbus_pkt_t'(exp_q.pop_front()));
                    end
                end else begin
                    hold_v   = 1'b1;
                    hold_pkt = bus.o_pkt;
                end
            end
            if (bus.o_size_err === 1'b1) serr_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_chunk(input logic [2:0] id, input int size, input bit eop,
                              input bit err, input int tag);
        bit got;
        int cyc;
        for (int k = 0; k < 192; k++) bus.i_dat[k] = pat(tag, k);
        bus.i_id    = id;
        bus.i_size  = 8'(size);
        bus.i_eop   = eop;
        bus.i_err   = err;
        bus.i_valid = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            got = bus.o_ready;
            @(posedge clk);
            #1;
            if (got) break;
            cyc++;
            if (cyc > 200) begin
                total++;
                bad++;
                $display("FAIL chunk_accept_timeout actual=not_accepted required=accepted tag=%0d", tag);
                break;
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad = 0;
        serr_cnt = 0;
        hold_v = 1'b0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_id = 3'd0;
        bus.i_size = 8'd0;
        bus.i_eop = 1'b0;
        bus.i_err = 1'b0;
        bus.i_dat = '0;
        bus.i_tx_rdy = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid",    64'(bus.o_valid),    64'd0);
        chk("rst_o_ready",    64'(bus.o_ready),    64'd0);
        chk("rst_o_size_err", 64'(bus.o_size_err), 64'd0);
        chk("rst_o_pkt_ena",  64'(bus.o_pkt.ena),  64'd0);
        total++;
        if (bus.o_pkt !== '0) begin
            bad++;
            $display("FAIL rst_o_pkt actual_nonzero required=zero");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_o_ready", 64'(bus.o_ready), 64'd1);
        @(posedge clk);
        #1;

        // 64-byte eop chunk alone
        exp_new(3'd0);
        exp_chunk(0, 4, 1, 1, 1, 0, 0);
        exp_push();
        send_chunk(3'd0, 64, 1'b1, 1'b0, 1);
        wait_drain();

        // three 60-byte eop chunks share one beat, one eop per quad
        exp_new(3'd0);
        exp_chunk(0, 4, 2, 1, 1, 4, 0);
        exp_chunk(4, 4, 3, 1, 1, 4, 0);
        exp_chunk(8, 4, 4, 1, 1, 4, 0);
        exp_push();
        send_chunk(3'd0, 60, 1'b1, 1'b0, 2);
        send_chunk(3'd0, 60, 1'b1, 1'b0, 3);
        send_chunk(3'd0, 60, 1'b1, 1'b0, 4);
        wait_drain();

        // 192-byte non-eop then 17-byte eop: packet spans two beats
        exp_new(3'd0);
        exp_chunk(0, 12, 5, 1, 0, 0, 0);
        exp_push();
        exp_new(3'd0);
        exp_chunk(0, 2, 6, 0, 1, 15, 0);
        exp_push();
        send_chunk(3'd0, 192, 1'b0, 1'b0, 5);
        send_chunk(3'd0, 17, 1'b1, 1'b0, 6);
        wait_drain();

        // id change forces separate beats
        exp_new(3'd1);
        exp_chunk(0, 2, 7, 1, 1, 0, 0);
        exp_push();
        exp_new(3'd2);
        exp_chunk(0, 2, 8, 1, 1, 0, 0);
        exp_push();
        send_chunk(3'd1, 32, 1'b1, 1'b0, 7);
        send_chunk(3'd2, 32, 1'b1, 1'b0, 8);
        wait_drain();

        // malformed chunks are dropped; the next good chunk still opens a packet
        send_chunk(3'd0, 20, 1'b0, 1'b0, 9);
        send_chunk(3'd0, 0, 1'b1, 1'b0, 9);
        send_chunk(3'd0, 200, 1'b1, 1'b0, 9);
        exp_new(3'd0);
        exp_chunk(0, 3, 10, 1, 1, 0, 0);
        exp_push();
        send_chunk(3'd0, 48, 1'b1, 1'b0, 10);
        wait_drain();
        chk("size_err_pulses", 64'(serr_cnt), 64'd3);

        // back-pressure with two full chunks
        bus.i_tx_rdy = 1'b0;
        exp_new(3'd3);
        exp_chunk(0, 12, 11, 1, 1, 0, 0);
        exp_push();
        exp_new(3'd3);
        exp_chunk(0, 12, 12, 1, 1, 0, 0);
        exp_push();
        fork
            begin
                send_chunk(3'd3, 192, 1'b1, 1'b0, 11);
                send_chunk(3'd3, 192, 1'b1, 1'b0, 12);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("stall_o_ready", 64'(bus.o_ready), 64'd0);
                chk("stall_o_valid", 64'(bus.o_valid), 64'd1);
                @(posedge clk);
                #1;
                bus.i_tx_rdy = 1'b1;
            end
        join
        wait_drain();

        // error marking: latched from a non-eop chunk, and direct on eop
        exp_new(3'd0);
        exp_chunk(0, 2, 14, 1, 0, 0, 0);
        exp_chunk(2, 1, 15, 0, 1, 0, ERR_EN);
        exp_push();
        send_chunk(3'd0, 32, 1'b0, 1'b1, 14);
        send_chunk(3'd0, 16, 1'b1, 1'b0, 15);
        wait_drain();
        exp_new(3'd0);
        exp_chunk(0, 2, 13, 1, 1, 0, ERR_EN);
        exp_push();
        send_chunk(3'd0, 32, 1'b1, 1'b1, 13);
        wait_drain();

        chk("size_err_total", 64'(serr_cnt), 64'd3);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
